id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// Ports: decode slot (in_valid/in_ready, regs, imm, pc, ctrl),
//        EX/MEM bypass info, flush, ALU-side handshake and operands.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic [3:0]  alu_op_in,
    input  logic        op1_sel,
    input  logic        op2_sel,
    input  logic        wen_in,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic [31:0] ex_result,
    input  logic [4:0]  mem_rd,
    input  logic        mem_wen,
    input  logic [31:0] mem_result,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd_out,
    output logic        wen_out,
    output logic [31:0] pc_out
);

    logic        out_valid_q, out_valid_d;
    logic        wen_q, wen_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d;

    logic        rs1_used, rs2_used;
    logic        hazard;
    logic        capture;
    logic [31:0] rs1_fwd, rs2_fwd;

    // EX wins over MEM; a load in EX has no value yet, so it is
    // never a bypass source (the stall covers that case).
    function automatic logic [31:0] resolve(
        input logic [4:0]  addr,
        input logic [31:0] rf_data
    );
        logic [31:0] r;
        r = rf_data;
        if (addr != 5'd0) begin
            if (ex_wen && !ex_is_load && addr == ex_rd)
                r = ex_result;
            else if (mem_wen && addr == mem_rd)
                r = mem_result;
        end
        return r;
    endfunction

    always_comb begin
        rs1_used = !op1_sel;
        rs2_used = !op2_sel;
        rs1_fwd  = resolve(rs1_addr, rs1_data);
        rs2_fwd  = resolve(rs2_addr, rs2_data);
        hazard   = in_valid && ex_is_load && ex_wen
                 && (ex_rd != 5'd0)
                 && ((rs1_used && rs1_addr == ex_rd)
                  || (rs2_used && rs2_addr == ex_rd));
        in_ready = !reset && !hazard && !flush
                 && (!out_valid_q || out_ready);
        capture  = in_valid && in_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        wen_d       = wen_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        if (reset) begin
            out_valid_d = 1'b0;
            wen_d       = 1'b0;
            op1_d       = '0;
            op2_d       = '0;
            alu_op_d    = '0;
            rd_d        = '0;
            pc_d        = '0;
        end else if (flush) begin
            out_valid_d = 1'b0;
            wen_d       = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            wen_d       = wen_in;
            op1_d       = op1_sel ? pc : rs1_fwd;
            op2_d       = op2_sel ? imm : rs2_fwd;
            alu_op_d    = alu_op_in;
            rd_d        = rd_addr;
            pc_d        = pc;
        end else if (out_valid_q && out_ready) begin
            // consumed with nothing behind it: bubble
            out_valid_d = 1'b0;
            wen_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        out_valid_q <= out_valid_d;
        wen_q       <= wen_d;
        op1_q       <= op1_d;
        op2_q       <= op2_d;
        alu_op_q    <= alu_op_d;
        rd_q        <= rd_d;
        pc_q        <= pc_d;
    end

    assign out_valid = out_valid_q;
    assign wen_out   = wen_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign alu_op    = alu_op_q;
    assign rd_out    = rd_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: transaction model plus directed vectors.
// Model is compared every cycle; literals pin key scenarios.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic [3:0]  alu_op_in;
    logic        op1_sel, op2_sel, wen_in;
    logic [4:0]  ex_rd;
    logic        ex_wen, ex_is_load;
    logic [31:0] ex_result;
    logic [4:0]  mem_rd;
    logic        mem_wen;
    logic [31:0] mem_result;
    logic        flush, out_ready;
    logic        out_valid;
    logic [31:0] op1, op2;
    logic [3:0]  alu_op;
    logic [4:0]  rd_out;
    logic        wen_out;
    logic [31:0] pc_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .pc(pc), .alu_op_in(alu_op_in),
        .op1_sel(op1_sel), .op2_sel(op2_sel), .wen_in(wen_in),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_result(mem_result),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .op1(op1), .op2(op2),
        .alu_op(alu_op), .rd_out(rd_out), .wen_out(wen_out),
        .pc_out(pc_out)
    );

    // ---------------- behavioural model ----------------
    // One held slot; fields are "known" after reset or an accept.
    typedef struct {
        bit          valid;
        bit          known;
        bit          wen;
        logic [31:0] op1, op2, pc;
        logic [3:0]  alu;
        logic [4:0]  rd;
    } slot_t;

    slot_t m;
    bit    started = 0;

    function automatic logic [31:0] m_src(input logic [4:0] a,
                                          input logic [31:0] d);
        if (a == 0) return d;
        if (a == ex_rd && ex_wen && !ex_is_load) return ex_result;
        if (a == mem_rd && mem_wen) return mem_result;
        return d;
    endfunction

    function automatic bit m_load_use();
        bit hit1, hit2;
        hit1 = !op1_sel && rs1_addr == ex_rd;
        hit2 = !op2_sel && rs2_addr == ex_rd;
        return in_valid && ex_is_load && ex_wen && ex_rd != 0
               && (hit1 || hit2);
    endfunction

    function automatic bit m_ready();
        if (reset || flush || m_load_use()) return 0;
        return !m.valid || out_ready;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m.valid = 0; m.known = 1; m.wen = 0;
            m.op1 = 0; m.op2 = 0; m.pc = 0; m.alu = 0; m.rd = 0;
            started = 1;
        end else if (flush) begin
            m.valid = 0; m.known = 0; m.wen = 0;
        end else if (in_valid && m_ready()) begin
            m.valid = 1; m.known = 1; m.wen = wen_in;
            m.op1 = op1_sel ? pc : m_src(rs1_addr, rs1_data);
            m.op2 = op2_sel ? imm : m_src(rs2_addr, rs2_data);
            m.pc = pc; m.alu = alu_op_in; m.rd = rd_addr;
        end else if (m.valid && out_ready) begin
            m.valid = 0; m.known = 0; m.wen = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // compare process: every cycle once reset has been seen
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m.valid});
            chk("wen_out", {31'b0, wen_out}, {31'b0, m.wen});
            if (m.known) begin
                chk("op1", op1, m.op1);
                chk("op2", op2, m.op2);
                chk("pc_out", pc_out, m.pc);
                chk("alu_op", {28'b0, alu_op}, {28'b0, m.alu});
                chk("rd_out", {27'b0, rd_out}, {27'b0, m.rd});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
        rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
        alu_op_in = 0; op1_sel = 0; op2_sel = 0; wen_in = 0;
        ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_result = 0;
        mem_rd = 0; mem_wen = 0; mem_result = 0;
        flush = 0; out_ready = 1;
    endtask

    logic [31:0] h_op1, h_op2, h_pc;

    initial begin
        idle();
        reset = 1;
        #1;
        chk("lit_ready_in_reset", {31'b0, in_ready}, 0);
        step();
        step();
        chk("lit_reset_valid", {31'b0, out_valid}, 0);
        chk("lit_reset_op1", op1, 0);
        reset = 0;

        // EX beats MEM on the same register
        in_valid = 1; rs1_addr = 5; op1_sel = 0; rs1_data = 32'h55;
        ex_rd = 5; ex_wen = 1; ex_result = 32'h11;
        mem_rd = 5; mem_wen = 1; mem_result = 32'h22;
        op2_sel = 1; imm = 3; alu_op_in = 4; rd_addr = 9;
        wen_in = 1; pc = 32'h100;
        step();
        chk("lit_fwd_ex", op1, 32'h11);
        chk("lit_fwd_ex_model", m.op1, 32'h11);
        chk("lit_fwd_valid", {31'b0, out_valid}, 1);

        // only MEM matches
        ex_wen = 0;
        step();
        chk("lit_fwd_mem", op1, 32'h22);

        // x0 never forwarded
        ex_rd = 0; ex_wen = 1; ex_result = 32'hFFFF_FFFF;
        mem_rd = 0; mem_wen = 1; mem_result = 32'hFFFF_FFFF;
        rs2_addr = 0; rs2_data = 0; op2_sel = 0;
        op1_sel = 1; pc = 32'h200;
        step();
        chk("lit_x0_op2", op2, 0);
        chk("lit_pc_op1", op1, 32'h200);
        mem_wen = 0;

        // load in EX but rs2 unused: no stall
        ex_is_load = 1; ex_wen = 1; ex_rd = 7;
        rs2_addr = 7; op2_sel = 1; imm = 32'h800;
        #1;
        chk("lit_no_false_stall", {31'b0, in_ready}, 1);
        step();
        chk("lit_imm_op2", op2, 32'h800);

        // load-use stall
        op2_sel = 0; rs2_data = 32'h77; rd_addr = 12;
        #1;
        chk("lit_load_use_ready", {31'b0, in_ready}, 0);
        step();
        chk("lit_load_use_bubble", {31'b0, out_valid}, 0);
        chk("lit_load_use_wen", {31'b0, wen_out}, 0);
        step();
        chk("lit_stall2_valid", {31'b0, out_valid}, 0);
        ex_is_load = 0; ex_result = 32'h99;
        step();
        chk("lit_after_stall_valid", {31'b0, out_valid}, 1);
        chk("lit_after_stall_op2", op2, 32'h99);
        chk("lit_after_stall_rd", {27'b0, rd_out}, 12);

        // high alu_op passes through
        ex_wen = 0; alu_op_in = 4'd15;
        step();
        chk("lit_alu15", {28'b0, alu_op}, 15);

        // backpressure then flush
        alu_op_in = 2; rd_addr = 3; wen_in = 1; pc = 32'h300;
        op1_sel = 1; op2_sel = 1; imm = 32'h44;
        step();
        h_op1 = op1; h_op2 = op2; h_pc = pc_out;
        out_ready = 0; pc = 32'h400; imm = 32'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_hold_valid", {31'b0, out_valid}, 1);
            chk("lit_hold_pc", pc_out, 32'h300);
            chk("lit_hold_op2", op2, 32'h44);
            chk("lit_hold_ready", {31'b0, in_ready}, 0);
        end
        flush = 1;
        step();
        flush = 0;
        chk("lit_flush_valid", {31'b0, out_valid}, 0);
        chk("lit_flush_wen", {31'b0, wen_out}, 0);

        // reset while holding
        out_ready = 1; pc = 32'h500;
        step();
        out_ready = 0;
        step();
        chk("lit_hold2_valid", {31'b0, out_valid}, 1);
        reset = 1;
        #1;
        chk("lit_ready_reset", {31'b0, in_ready}, 0);
        step();
        chk("lit_rst_valid", {31'b0, out_valid}, 0);
        chk("lit_rst_wen", {31'b0, wen_out}, 0);
        chk("lit_rst_op1", op1, 0);
        chk("lit_rst_op2", op2, 0);
        chk("lit_rst_pc", pc_out, 0);
        chk("lit_rst_alu", {28'b0, alu_op}, 0);
        chk("lit_rst_rd", {27'b0, rd_out}, 0);
        reset = 0; in_valid = 0; out_ready = 1;
        step();
        chk("lit_post_rst_valid", {31'b0, out_valid}, 0);

        // mixed traffic, checked by the model each cycle
        for (int i = 0; i < 80; i++) begin
            in_valid   = $urandom_range(0, 3) != 0;
            out_ready  = $urandom_range(0, 2) != 0;
            flush      = $urandom_range(0, 15) == 0;
            rs1_addr   = 5'($urandom_range(0, 3));
            rs2_addr   = 5'($urandom_range(0, 3));
            rd_addr    = 5'($urandom_range(0, 31));
            rs1_data   = $urandom;
            rs2_data   = $urandom;
            imm        = $urandom;
            pc         = $urandom;
            alu_op_in  = 4'($urandom_range(0, 15));
            op1_sel    = 1'($urandom_range(0, 1));
            op2_sel    = 1'($urandom_range(0, 1));
            wen_in     = 1'($urandom_range(0, 1));
            ex_rd      = 5'($urandom_range(0, 3));
            ex_wen     = 1'($urandom_range(0, 1));
            ex_is_load = $urandom_range(0, 3) == 0;
            ex_result  = $urandom;
            mem_rd     = 5'($urandom_range(0, 3));
            mem_wen    = 1'($urandom_range(0, 1));
            mem_result = $urandom;
            step();
        end
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
